// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and helpers for the UART receiver
`timescale 1ns/1ps
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_t;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  localparam int HALF_BIT_DEF = half_bit(CLKS_PER_BIT_DEF);

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an asynchronous pin, resets to 1 (idle line)
`timescale 1ns/1ps
module uart_rx_sync (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: start qualification, mid-bit 2-of-3 voting, valid/ready output
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int H  = half_bit(CLKS_PER_BIT);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_A    = CW'(H - 1);
  localparam logic [CW-1:0] CNT_B    = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rs;
  logic                 rs_prev;
  logic                 s_a;
  logic                 s_b;
  logic                 fall;
  logic                 maj;
  logic                 in_frame;
  logic                 decide;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;

  uart_rx_sync u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (rx),
    .q    (rs)
  );

  always_comb begin
    fall     = rs_prev & ~rs;
    maj      = (s_a & s_b) | (s_a & rs) | (s_b & rs);
    in_frame = (state == START) || (state == DATA) || (state == STOP);
    decide   = in_frame && (cnt == CNT_DEC);
  end

  assign busy = (state != IDLE);

  // cnt sits at 0 in IDLE, so the cycle that sees the falling edge is cycle 0 of the start bit.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rs_prev   <= 1'b1;
      s_a       <= 1'b1;
      s_b       <= 1'b1;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rs_prev   <= rs;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (cnt == CNT_A) s_a <= rs;
      if (cnt == CNT_B) s_b <= rs;

      if (in_frame || (state == IDLE && fall))
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      else
        cnt <= '0;

      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) state <= START;
        end
        START: begin
          if (decide) begin
            state <= maj ? IDLE : DATA;
            idx   <= '0;
          end
        end
        DATA: begin
          if (decide) begin
            shift <= {maj, shift[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end
        end
        STOP: begin
          // Leaving at mid-stop lets the next start edge be caught on back-to-back frames.
          if (decide) begin
            if (maj) begin
              state <= IDLE;
              if (!valid || ready) begin
                data  <= shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= BRK;
              frame_err <= 1'b1;
            end
          end
        end
        BRK: begin
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with randomized bytes and ready
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB    = 16;
  localparam int H      = CPB / 2;
  localparam int BIT_NS = CPB * 20;
  localparam int LAT    = 9 * CPB + H + 4;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int rdy_mode = 1;
  int checks = 0;
  int failures = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  int xfers = 0;
  int x0;
  int lat;
  int got;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;
  logic [7:0] rnd_b;
  logic [7:0] prev_data = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_xfer = 1'b0;
  logic       prev_fe = 1'b0;
  logic       prev_ov = 1'b0;

  always #10 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .rx        (rx),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(posedge clk) begin
    #2;
    ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  task automatic check(input string name, input int got_v, input int exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (nRst) begin
      if (valid && ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got byte 0x%0h expected none", data);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_data", int'(data), int'(sb_exp));
        end
      end
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      if (frame_err && overrun) begin
        failures++;
        $display("FAIL err_exclusive: got frame_err=1 overrun=1 expected not both");
      end
      if (prev_valid && !prev_xfer && valid && data !== prev_data) begin
        failures++;
        $display("FAIL data_stable: got 0x%0h expected 0x%0h", data, prev_data);
      end
      if ((frame_err && prev_fe) || (overrun && prev_ov)) begin
        failures++;
        $display("FAIL pulse_width: got pulse longer than 1 cycle expected 1");
      end
      prev_data  = data;
      prev_valid = valid;
      prev_xfer  = valid && ready;
      prev_fe    = frame_err;
      prev_ov    = overrun;
    end else begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
      prev_fe    = 1'b0;
      prev_ov    = 1'b0;
    end
  end

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = stop_bit;
    #(BIT_NS);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    align();
    nRst = 1'b1;
    repeat (5) @(posedge clk);

    // single byte, latency from pin edge
    align();
    exp_q.push_back(8'hAA);
    x0 = xfers;
    lat = 0;
    got = 0;
    fork
      send_frame(8'hAA, 1'b1);
      begin
        for (int i = 0; i < LAT + 50 && got == 0; i++) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (valid) got = 1;
        end
      end
    join
    check("t1_valid_seen", got, 1);
    check("t1_latency", lat, LAT);
    wait_drain("t1_drain");
    check("t1_one_valid", xfers - x0, 1);
    check("t1_no_err", fe_seen + ov_seen, 0);

    // 0x00..0xFF back to back
    align();
    x0 = xfers;
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    wait_drain("t2_drain");
    check("t2_count", xfers - x0, 256);
    check("t2_frame_err", fe_seen, exp_fe);
    check("t2_overrun", ov_seen, exp_ov);

    // start-bit glitch rejected
    align();
    x0 = xfers;
    rx = 1'b0;
    #100;
    rx = 1'b1;
    @(negedge clk);
    check("t3_busy_glitch", int'(busy), 1);
    for (int i = 0; i < H + 2 && busy; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t3_busy_idle", int'(busy), 0);
    #(10 * BIT_NS);
    check("t3_no_output", xfers - x0, 0);
    align();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain("t3_drain");
    check("t3_count", xfers - x0, 1);

    // framing error, held-low line, recovery
    align();
    x0 = xfers;
    exp_fe++;
    send_frame(8'h3C, 1'b0);
    #(2 * BIT_NS);
    rx = 1'b1;
    #(2 * BIT_NS);
    check("t4_frame_err", fe_seen, exp_fe);
    check("t4_busy_released", int'(busy), 0);
    check("t4_no_byte", xfers - x0, 0);
    align();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_drain("t4_drain");
    check("t4_count", xfers - x0, 1);

    // overrun with consumer stalled
    rdy_mode = 0;
    align();
    align();
    send_frame(8'h11, 1'b1);
    #(2 * BIT_NS);
    check("t5_valid_held", int'(valid), 1);
    check("t5_data_held", int'(data), 8'h11);
    exp_ov++;
    send_frame(8'h22, 1'b1);
    #(2 * BIT_NS);
    check("t5_overrun", ov_seen, exp_ov);
    check("t5_data_kept", int'(data), 8'h11);
    check("t5_valid_kept", int'(valid), 1);
    exp_q.push_back(8'h11);
    rdy_mode = 1;
    @(posedge clk);
    #3;
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_drop", int'(valid), 0);
    check("t5_queue", exp_q.size(), 0);

    // asynchronous reset mid-frame
    rdy_mode = 0;
    align();
    align();
    send_frame(8'hAB, 1'b1);
    #(BIT_NS);
    check("t6_pre_valid", int'(valid), 1);
    align();
    x0 = xfers;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        #(4 * BIT_NS + BIT_NS / 2);
        nRst = 1'b0;
        #1;
        check("t6_rst_data", int'(data), 0);
        check("t6_rst_valid", int'(valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_errs", int'(frame_err) + int'(overrun), 0);
      end
    join
    rx = 1'b1;
    #(BIT_NS);
    align();
    nRst = 1'b1;
    rdy_mode = 1;
    #(2 * BIT_NS);
    check("t6_no_byte", xfers - x0, 0);
    align();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    wait_drain("t6_drain");
    check("t6_count", xfers - x0, 1);

    // random bytes, random gaps, random ready
    rdy_mode = 2;
    align();
    x0 = xfers;
    for (int n = 0; n < 30; n++) begin
      rnd_b = 8'($urandom);
      exp_q.push_back(rnd_b);
      send_frame(rnd_b, 1'b1);
      #($urandom_range(0, 2) * BIT_NS);
    end
    wait_drain("t7_drain");
    check("t7_count", xfers - x0, 30);
    rdy_mode = 1;

    check("final_frame_err", fe_seen, exp_fe);
    check("final_overrun", ov_seen, exp_ov);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver that deserialises the top-level rx pin into bytes for the command/data path behind `top`. It oversamples at the system clock (50 MHz, 20 ns), detects and qualifies the start bit, and majority-samples each bit at mid-period. Completed bytes go out on a valid/ready handshake, with framing-error and overrun indications. It is the receiving end of the serial link the bench drives at 8680 ns per bit.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200 baud); must be at least 8.
DATA_BITS, 8, payload bits per frame, LSB first.

Ports:
clk  in  1  system clock, 50 MHz.
nRst  in  1  reset, asynchronous, active-low.
rx  in  1  serial line, idle high, asynchronous to clk.
ready  in  1  consumer accepts data when ready=1 and valid=1.
data  out  8  received byte, stable while valid=1.
valid  out  1  byte available; held until accepted.
frame_err  out  1  one-cycle pulse when the stop bit samples 0.
overrun  out  1  one-cycle pulse when a byte is dropped because the output is still occupied.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (nRst=0, asynchronous):
  - data=0x00, valid=0, frame_err=0, overrun=0, busy=0.
  - Both synchroniser flops reset to 1, so releasing reset never produces a false start.
  - Reset mid-frame aborts the frame; FSM returns to IDLE and the partial byte is discarded.
- rx passes a 2-flop synchroniser; all logic uses the synchronised value rs.
- Bit timer: cnt runs 0..CLKS_PER_BIT-1 and wraps. H = CLKS_PER_BIT/2 (integer).
- Sample points: rs is sampled at cnt = H-1, H and H+1. The bit value is the 2-of-3 majority, decided at cnt = H+1.
- FSM states:
  - IDLE: a falling edge on rs (prev=1, now=0) sets cnt=0 and moves to START.
  - START: majority at H+1. If 1, it is a glitch: go to IDLE with no output. If 0, go to DATA with bit index 0.
  - DATA: at each H+1 decision, shift the majority into shift[7] (right-shift, LSB first) and increment the index. After index 7 is captured, go to STOP.
  - STOP, majority 1: commit the byte and go to IDLE immediately, half a bit early, so back-to-back frames with a 1-bit stop are received.
  - STOP, majority 0: pulse frame_err, discard the byte, go to BRK.
  - BRK: wait for rs=1, then go to IDLE. This stops a held-low line from being re-detected as a start.
- Commit, one cycle after the stop-bit decision:
  - valid=0, or valid=1 with ready=1 in the same cycle: data<=shift, valid<=1.
  - valid=1 with ready=0: data unchanged, overrun pulses for 1 cycle, new byte dropped.
- Handshake:
  - valid&&ready with no commit that cycle clears valid on the next edge.
  - data never changes while valid=1 unless a transfer occurs in that same cycle.
- Latency: from the rs falling edge, valid rises at 9*CLKS_PER_BIT + H + 2 cycles, plus 2 synchroniser cycles from the pin.
- Tolerance: with CLKS_PER_BIT=434, frames with a baud error within ±3% are received correctly.
- frame_err and overrun are never asserted in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - CLKS_PER_BIT default (434).
  - DATA_BITS (8).
  - FSM state encoding: IDLE, START, DATA, STOP, BRK.
  - A helper constant for H.
- One sub-module, uart_rx_sync: a 2-flop synchroniser with reset value 1 on asynchronous active-low reset, reusable for other asynchronous pins.

Test Plan:
1. ready=1, send 0xAA at 8680 ns/bit -> exactly one valid pulse with data=0xAA; frame_err=0 and overrun=0 throughout.
2. ready=1, send 0x00..0xFF back-to-back with a 1-bit stop and no idle gap -> 256 bytes received in order; no frame_err, no overrun.
3. rx low for 100 ns (5 clocks), then high; 100 µs later send 0x55 -> no output from the glitch; then data=0x55 with valid; busy back to 0 within H+2 cycles of the glitch.
4. Send 0x3C with the stop bit forced to 0, hold rx low for 2 bit times, release; then send 0xC3 -> one frame_err pulse, no valid for 0x3C; then valid with data=0xC3.
5. ready=0, send 0x11 then 0x22 -> data stays 0x11 with valid=1; one overrun pulse at the 0x22 commit; raise ready -> 0x11 accepted and valid drops next cycle.
6. Assert nRst low during bit 3 of 0xF0, release, then send 0x0F -> outputs at reset values immediately; no byte from 0xF0; then data=0x0F with valid.
